// File: rtl/keccak_rho_pi_stream_if.sv
// Lane stream bundle for keccak_rho_pi_stream; in_last/err exist only with KECCAK_RHOPI_LAST_CHECK_EN.
// slave is the rho/pi unit's view, master is the neighbouring theta/chi side.
interface keccak_rho_pi_stream_if #(
    parameter int LANE_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [LANE_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [LANE_W-1:0] out_data;
    logic [4:0]        out_idx;
    logic              out_last;
`ifdef KECCAK_RHOPI_LAST_CHECK_EN
    logic              in_last;
    logic              err;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, err
    );
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, err
    );
`else
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );
`endif
endinterface

// File: rtl/keccak_rho_pi_stream.sv
// Keccak rho rotation + pi destination index, one lane per cycle; optional KECCAK_RHOPI_LAST_CHECK_EN frame-end check.
// Latency 1 cycle; in_ready = !out_valid || out_ready (forced low by flush), output held stable while stalled.
module keccak_rho_pi_stream #(
    parameter int LANE_W = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    keccak_rho_pi_stream_if.slave  bus,
    output logic [4:0]             lane_cnt
);
    localparam bit LANE_W_OK = (LANE_W == 1) || (LANE_W == 2) || (LANE_W == 4) || (LANE_W == 8) ||
                               (LANE_W == 16) || (LANE_W == 32) || (LANE_W == 64);

    generate
        if (!LANE_W_OK) begin : g_bad_lane_w
            $error("keccak_rho_pi_stream: LANE_W must be 1, 2, 4, 8, 16, 32 or 64");
        end
    endgenerate

    function automatic logic [5:0] rho_off(input logic [4:0] i);
        case (i)
            5'd0:  rho_off = 6'd0;
            5'd1:  rho_off = 6'd1;
            5'd2:  rho_off = 6'd62;
            5'd3:  rho_off = 6'd28;
            5'd4:  rho_off = 6'd27;
            5'd5:  rho_off = 6'd36;
            5'd6:  rho_off = 6'd44;
            5'd7:  rho_off = 6'd6;
            5'd8:  rho_off = 6'd55;
            5'd9:  rho_off = 6'd20;
            5'd10: rho_off = 6'd3;
            5'd11: rho_off = 6'd10;
            5'd12: rho_off = 6'd43;
            5'd13: rho_off = 6'd25;
            5'd14: rho_off = 6'd39;
            5'd15: rho_off = 6'd41;
            5'd16: rho_off = 6'd45;
            5'd17: rho_off = 6'd15;
            5'd18: rho_off = 6'd21;
            5'd19: rho_off = 6'd8;
            5'd20: rho_off = 6'd18;
            5'd21: rho_off = 6'd2;
            5'd22: rho_off = 6'd61;
            5'd23: rho_off = 6'd56;
            5'd24: rho_off = 6'd14;
            default: rho_off = 6'd0;
        endcase
    endfunction

    // 2x+3y tops out at 20, which the default maps to 0 correctly.
    function automatic logic [2:0] mod5(input logic [4:0] v);
        case (v)
            5'd0,  5'd5,  5'd10, 5'd15: mod5 = 3'd0;
            5'd1,  5'd6,  5'd11, 5'd16: mod5 = 3'd1;
            5'd2,  5'd7,  5'd12, 5'd17: mod5 = 3'd2;
            5'd3,  5'd8,  5'd13, 5'd18: mod5 = 3'd3;
            5'd4,  5'd9,  5'd14, 5'd19: mod5 = 3'd4;
            default:                    mod5 = 3'd0;
        endcase
    endfunction

    logic              out_valid_q;
    logic [LANE_W-1:0] out_data_q;
    logic [4:0]        out_idx_q;
    logic              out_last_q;
    logic [4:0]        cnt_q;

    logic              in_ready;
    logic              accept;
    logic [6:0]        rot_amt;
    logic [LANE_W-1:0] rot_data;
    logic [4:0]        px;
    logic [4:0]        py;
    logic [4:0]        psum;
    logic [2:0]        pyp;
    logic [4:0]        pidx;

    assign in_ready = !flush && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    // Lane widths are powers of two, so mod LANE_W is a mask.
    assign rot_amt  = 7'(rho_off(cnt_q)) & 7'(LANE_W - 1);
    assign rot_data = LANE_W'(({bus.in_data, bus.in_data} << rot_amt) >> LANE_W);

    always_comb begin
        py = 5'd0;
        if (cnt_q >= 5'd20)      py = 5'd4;
        else if (cnt_q >= 5'd15) py = 5'd3;
        else if (cnt_q >= 5'd10) py = 5'd2;
        else if (cnt_q >= 5'd5)  py = 5'd1;
        px   = cnt_q - ((py << 2) + py);
        psum = (px << 1) + (py << 1) + py;
        pyp  = mod5(psum);
        pidx = py + (5'(pyp) << 2) + 5'(pyp);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= 5'd0;
            out_last_q  <= 1'b0;
            cnt_q       <= 5'd0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= rot_data;
            out_idx_q   <= pidx;
            out_last_q  <= (cnt_q == 5'd24);
            cnt_q       <= (cnt_q == 5'd24) ? 5'd0 : cnt_q + 5'd1;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef KECCAK_RHOPI_LAST_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            err_q <= 1'b0;
        end else if (accept && (bus.in_last != (cnt_q == 5'd24))) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;
    assign lane_cnt      = cnt_q;
endmodule

// File: tb/tb_keccak_rho_pi_stream.sv
// Directed bench for keccak_rho_pi_stream at LANE_W=64 and LANE_W=8; err checks with KECCAK_RHOPI_LAST_CHECK_EN.
module tb_keccak_rho_pi_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       flush;
    logic       tb_last;
    logic [4:0] lane_cnt;
    logic [4:0] lane_cnt8;

    keccak_rho_pi_stream_if #(.LANE_W(64)) b64();
    keccak_rho_pi_stream_if #(.LANE_W(8))  b8();

`ifdef KECCAK_RHOPI_LAST_CHECK_EN
    assign b64.in_last = tb_last;
    assign b8.in_last  = tb_last;
`endif

    keccak_rho_pi_stream #(.LANE_W(64)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(b64), .lane_cnt(lane_cnt)
    );
    keccak_rho_pi_stream #(.LANE_W(8)) dut8 (
        .clk(clk), .rst(rst), .flush(flush), .bus(b8), .lane_cnt(lane_cnt8)
    );

    typedef struct {
        logic [63:0] din;
        logic [63:0] dout;
        logic [4:0]  idx;
        logic        last;
    } vec_t;

    int rho[25]   = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                      41, 45, 15, 21, 8, 18, 2, 61, 56, 14};
    int pi_idx[25] = '{0, 10, 20, 5, 15, 16, 1, 11, 21, 6, 7, 17, 2, 12, 22,
                       23, 8, 18, 3, 13, 14, 24, 9, 19, 4};
    vec_t vt[25];
    int checks   = 0;
    int failures = 0;

    function automatic logic [63:0] rotl64(input logic [63:0] d, input int a);
        if (a == 0) return d;
        return (d << a) | (d >> (64 - a));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic flush_frame;
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 25; i++) begin
            vt[i].din  = 64'(i);
            vt[i].dout = rotl64(64'(i), rho[i]);
            vt[i].idx  = 5'(pi_idx[i]);
            vt[i].last = (i == 24);
        end

        rst = 1'b1; flush = 1'b0; tb_last = 1'b0;
        b64.in_valid = 1'b0; b64.in_data = '0; b64.out_ready = 1'b1;
        b8.in_valid  = 1'b0; b8.in_data  = '0; b8.out_ready  = 1'b1;
        repeat (3) step();
        chk("rst_out_valid", 64'(b64.out_valid), 64'd0);
        chk("rst_out_data",  b64.out_data, 64'd0);
        chk("rst_out_idx",   64'(b64.out_idx), 64'd0);
        chk("rst_out_last",  64'(b64.out_last), 64'd0);
        chk("rst_lane_cnt",  64'(lane_cnt), 64'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 64'(b64.in_ready), 64'd1);

        // Full frame at one lane per cycle
        for (int i = 0; i < 25; i++) begin
            b64.in_valid = 1'b1;
            b64.in_data  = vt[i].din;
            tb_last      = vt[i].last;
            chk($sformatf("stream_in_ready[%0d]", i), 64'(b64.in_ready), 64'd1);
            step();
            chk($sformatf("stream_valid[%0d]", i), 64'(b64.out_valid), 64'd1);
            chk($sformatf("stream_data[%0d]", i),  b64.out_data, vt[i].dout);
            chk($sformatf("stream_idx[%0d]", i),   64'(b64.out_idx), 64'(vt[i].idx));
            chk($sformatf("stream_last[%0d]", i),  64'(b64.out_last), 64'(vt[i].last));
            chk($sformatf("stream_cnt[%0d]", i),   64'(lane_cnt), 64'((i + 1) % 25));
`ifdef KECCAK_RHOPI_LAST_CHECK_EN
            chk($sformatf("good_frame_err[%0d]", i), 64'(b64.err), 64'd0);
`endif
        end
        b64.in_valid = 1'b0; tb_last = 1'b0;
        step();
        chk("drain_out_valid", 64'(b64.out_valid), 64'd0);
        chk("drain_lane_cnt",  64'(lane_cnt), 64'd0);

        // Wrap-around bit of a rotate-by-1
        b64.in_valid = 1'b1; b64.in_data = 64'd0;
        step();
        b64.in_data = 64'h8000_0000_0000_0001;
        step();
        chk("wrap_rot_data", b64.out_data, 64'h0000_0000_0000_0003);
        chk("wrap_rot_idx",  64'(b64.out_idx), 64'd10);
        b64.in_valid = 1'b0;
        flush_frame();
        chk("wrap_flush_cnt", 64'(lane_cnt), 64'd0);

        // Backpressure: hold the first output for 3 cycles
        b64.in_valid = 1'b1; b64.in_data = 64'hDEAD_BEEF_0123_4567;
        step();
        b64.out_ready = 1'b0;
        b64.in_data   = 64'd1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_in_ready[%0d]", k), 64'(b64.in_ready), 64'd0);
            step();
            chk($sformatf("bp_valid[%0d]", k), 64'(b64.out_valid), 64'd1);
            chk($sformatf("bp_data[%0d]", k),  b64.out_data, 64'hDEAD_BEEF_0123_4567);
            chk($sformatf("bp_idx[%0d]", k),   64'(b64.out_idx), 64'd0);
            chk($sformatf("bp_cnt[%0d]", k),   64'(lane_cnt), 64'd1);
        end
        b64.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 64'(b64.in_ready), 64'd1);
        step();
        chk("bp_next_idx",  64'(b64.out_idx), 64'd10);
        chk("bp_next_data", b64.out_data, 64'd2);
        chk("bp_next_cnt",  64'(lane_cnt), 64'd2);
        b64.in_valid = 1'b0;
        step();
        chk("bp_drain_valid", 64'(b64.out_valid), 64'd0);
        flush_frame();

        // Flush after lane 7 while the output register is full
        for (int i = 0; i < 8; i++) begin
            b64.in_valid = 1'b1; b64.in_data = vt[i].din;
            step();
        end
        chk("pre_flush_idx",   64'(b64.out_idx), 64'd11);
        chk("pre_flush_valid", 64'(b64.out_valid), 64'd1);
        flush = 1'b1; b64.in_data = 64'd8;
        #1;
        chk("flush_in_ready", 64'(b64.in_ready), 64'd0);
        step();
        flush = 1'b0;
        chk("flush_out_valid", 64'(b64.out_valid), 64'd0);
        chk("flush_lane_cnt",  64'(lane_cnt), 64'd0);
        b64.in_data = 64'd5;
        step();
        chk("post_flush_valid", 64'(b64.out_valid), 64'd1);
        chk("post_flush_idx",   64'(b64.out_idx), 64'd0);
        chk("post_flush_data",  b64.out_data, 64'd5);
        chk("post_flush_cnt",   64'(lane_cnt), 64'd1);
        b64.in_valid = 1'b0;
        step();

        // Reset beats flush and a live handshake
        b64.in_valid = 1'b1; b64.in_data = 64'd3;
        rst = 1'b1; flush = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0; b64.in_valid = 1'b0;
        chk("rst_prio_valid", 64'(b64.out_valid), 64'd0);
        chk("rst_prio_cnt",   64'(lane_cnt), 64'd0);

`ifdef KECCAK_RHOPI_LAST_CHECK_EN
        // Wrong in_last on lane 10 latches err until flush
        for (int i = 0; i < 25; i++) begin
            b64.in_valid = 1'b1; b64.in_data = vt[i].din;
            tb_last = (i == 10);
            step();
            chk($sformatf("bad_frame_err[%0d]", i), 64'(b64.err), (i >= 10) ? 64'd1 : 64'd0);
        end
        b64.in_valid = 1'b0; tb_last = 1'b0;
        step();
        chk("err_sticky_idle", 64'(b64.err), 64'd1);
        flush_frame();
        chk("err_flush_clear", 64'(b64.err), 64'd0);
`endif

        // LANE_W=8: rotation amounts reduce mod 8
        flush_frame();
        for (int i = 0; i < 25; i++) begin
            b8.in_valid = 1'b1; b8.in_data = 8'h01;
            tb_last = (i == 24);
            step();
            chk($sformatf("w8_data[%0d]", i), 64'(b8.out_data), 64'(8'(8'h01 << (rho[i] % 8))));
            chk($sformatf("w8_idx[%0d]", i),  64'(b8.out_idx), 64'(pi_idx[i]));
        end
        b8.in_valid = 1'b0; tb_last = 1'b0;
        step();
        chk("w8_lane_cnt", 64'(lane_cnt8), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
